// File: rtl/ieeedrv_headpos_if.sv
`default_nettype none
// ============================================================================
// Module   : ieeedrv_headpos_if
// Purpose  : Save-request handshake between head tracker and image buffer.
// Revision : 1.0
// ============================================================================
interface ieeedrv_headpos_if;
  logic       save_valid;
  logic [1:0] save_drv;
  logic [7:0] save_track;
  logic       save_ack;

  modport master (output save_valid, save_drv, save_track, input save_ack);
  modport slave  (input save_valid, save_drv, save_track, output save_ack);
endinterface
`default_nettype wire

// File: rtl/ieeedrv_headpos.sv
`default_nettype none
// ============================================================================
// Module   : ieeedrv_headpos
// Purpose  : Multi-drive stepper head tracker with dirty-track save arbiter.
// Revision : 1.0
// ============================================================================
module ieeedrv_headpos #(
  parameter int NDRV        = 2,
  parameter int SIDE0_START = 1,
  parameter int SIDE1_START = 78,
  parameter int SAVE_DELAY  = 8_000_000,
  parameter int SETTLE_4040 = 'h4_0000,
  parameter int SETTLE_8250 = 'h2_0000,
  parameter int HD_DELAY    = 1023
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce,
  input  logic                drv_type,
  input  logic [NDRV-1:0]     mounted,
  input  logic [1:0]          sel,
  input  logic                active,
  input  logic                changing,
  input  logic [NDRV-1:0]     mtr,
  input  logic [2*NDRV-1:0]   stp,
  input  logic                we,
  input  logic                rw,
  input  logic [NDRV-1:0]     hd,
  output logic [8*NDRV-1:0]   track,
  output logic [NDRV-1:0]     track_changing,
  ieeedrv_headpos_if.master   save
);

  localparam int            CW      = 24;
  localparam logic [CW-1:0] SET4040 = CW'(SETTLE_4040);
  localparam logic [CW-1:0] SET8250 = CW'(SETTLE_8250);
  localparam logic [CW-1:0] SAVE_LD = CW'(SAVE_DELAY);
  localparam logic [CW-1:0] HD_LD   = CW'(HD_DELAY);

  typedef enum logic [0:0] {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t          state;
  logic [1:0]      rr_ptr;
  logic            rw_prev;
  logic [NDRV-1:0] pend;
  logic [7:0]      ptrack_all [NDRV];
  logic            found;
  logic [1:0]      pick;
  logic [7:0]      pick_track;

  for (genvar i = 0; i < NDRV; i++) begin : g_drv
    logic [1:0]    stp_r, stp_prev, delta;
    logic          step_in, step_out, step_acc, hd_prev, hd_chg, is_sel, trig, ack_hit;
    logic [8:0]    htrack, hmax, hdir;
    logic [7:0]    calc, track_q, ptrack;
    logic [CW-1:0] settle, hd_cnt, save_cnt;
    logic          tc, dirty, pending;

    assign delta    = stp_r - stp_prev;
    assign step_in  = (delta == 2'd1);
    assign step_out = (delta == 2'd3);
    assign step_acc = step_in | step_out;
    assign hd_chg   = (hd[i] != hd_prev);
    assign is_sel   = active && (sel == 2'(i));
    assign hmax     = drv_type ? 9'd84 : 9'd304;
    assign hdir     = drv_type ? 9'd34 : 9'd152;
    // Side offset uses the registered head so a side change is hidden behind settle
    assign calc     = drv_type ? 8'(htrack[7:1]) + 8'(SIDE0_START)
                               : 8'(htrack[8:2]) + (hd_prev ? 8'(SIDE1_START) : 8'(SIDE0_START));
    assign trig     = dirty && !pending &&
                      (changing || step_acc || (is_sel && (!mtr[i] || hd_cnt == '0 || save_cnt == '0)));
    assign ack_hit  = (state == PRESENT) && save.save_ack && (save.save_drv == 2'(i));

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        stp_r    <= stp[2*i +: 2];
        stp_prev <= stp[2*i +: 2];
        hd_prev  <= hd[i];
        htrack   <= hdir;
        track_q  <= drv_type ? 8'(17 + SIDE0_START) : 8'(38 + SIDE0_START);
        settle   <= '0;
        hd_cnt   <= '0;
        save_cnt <= '0;
        tc       <= 1'b0;
        dirty    <= 1'b0;
        pending  <= 1'b0;
        ptrack   <= '0;
      end else begin
        stp_r    <= stp[2*i +: 2];
        stp_prev <= stp_r;
        hd_prev  <= hd[i];
        tc       <= (settle != '0);
        if (settle == '0) track_q <= calc;

        if (mounted[i])                        htrack <= hdir;
        else if (step_in && htrack < hmax)     htrack <= htrack + 9'd1;
        else if (step_out && htrack != 9'd0)   htrack <= htrack - 9'd1;

        if (mounted[i])                        settle <= '0;
        else if (step_acc || hd_chg)           settle <= drv_type ? SET4040 : SET8250;
        else if (is_sel && rw_prev && !rw)     settle <= '0;
        else if (ce && settle != '0)           settle <= settle - 1'b1;

        if (hd_chg)                            hd_cnt <= '0;
        else if (is_sel)                       hd_cnt <= HD_LD;
        else if (ce && hd_cnt != '0)           hd_cnt <= hd_cnt - 1'b1;

        if (trig || (is_sel && (!dirty || we))) save_cnt <= SAVE_LD;
        else if (ce && save_cnt != '0)          save_cnt <= save_cnt - 1'b1;

        if (mounted[i])                        dirty <= 1'b0;
        else if (trig)                         dirty <= 1'b0;
        else if (is_sel && we)                 dirty <= 1'b1;

        if (mounted[i])                        pending <= 1'b0;
        else if (trig)                         pending <= 1'b1;
        else if (ack_hit)                      pending <= 1'b0;

        if (trig) ptrack <= track_q;
      end
    end

    assign track[8*i +: 8]   = track_q;
    assign track_changing[i] = tc;
    assign pend[i]           = pending;
    assign ptrack_all[i]     = ptrack;
  end

  // Round-robin: first pending drive at or after rr_ptr, wrapping
  always_comb begin
    found      = 1'b0;
    pick       = '0;
    pick_track = '0;
    for (int k = 0; k < NDRV; k++) begin
      for (int j = 0; j < NDRV; j++) begin
        if (!found && pend[j] && (j == (int'(rr_ptr) + k) % NDRV)) begin
          found      = 1'b1;
          pick       = 2'(j);
          pick_track = ptrack_all[j];
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      rw_prev         <= rw;
      save.save_valid <= 1'b0;
      save.save_drv   <= '0;
      save.save_track <= '0;
    end else begin
      rw_prev <= rw;
      case (state)
        IDLE: begin
          if (found) begin
            save.save_valid <= 1'b1;
            save.save_drv   <= pick;
            save.save_track <= pick_track;
            state           <= PRESENT;
          end
        end
        PRESENT: begin
          if (save.save_ack) begin
            save.save_valid <= 1'b0;
            rr_ptr          <= (save.save_drv == 2'(NDRV - 1)) ? 2'd0 : save.save_drv + 2'd1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
